// File: rtl/fifo_rd_pkg.sv
// Shared constants and helpers for the FIFO read-side unload stage.
// The statistics counters are compiled in only with FIFO_RD_STATS_EN defined.
package fifo_rd_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 8;
   localparam int unsigned SKID_DEPTH_DEF = 3;
   localparam int unsigned STAT_W         = 32;
   localparam logic [STAT_W-1:0] STAT_MAX = '1;

   // Bits needed to index 'value' entries; never less than one.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready output stream seen by fifo_rd_stream.
// master = the unload stage, slave = FIFO read side and downstream sink.
interface fifo_rd_stream_if
   import fifo_rd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) ();

   logic                  r_empty;
   logic                  r_en;
   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  m_valid;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_ready;

   modport master (
      input  r_empty, r_valid, r_data, m_ready,
      output r_en, m_valid, m_data
   );

   modport slave (
      output r_empty, r_valid, r_data, m_ready,
      input  r_en, m_valid, m_data
   );

endinterface

// File: rtl/fifo_rd_skid_buf.sv
// Circular skid buffer: storage, wrapping pointers and occupancy count.
// Depth need not be a power of two; pointers wrap explicitly.
module fifo_rd_skid_buf
   import fifo_rd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned SKID_DEPTH = SKID_DEPTH_DEF
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  i_wr_en,
   input  logic [DATA_WIDTH-1:0]                 i_wr_data,
   input  logic                                  i_rd_en,
   output logic [clog2(SKID_DEPTH + 1)-1:0]      o_count,
   output logic [DATA_WIDTH-1:0]                 o_rd_data_c
);

   localparam int unsigned PTR_W = clog2(SKID_DEPTH);
   localparam int unsigned CNT_W = clog2(SKID_DEPTH + 1);

   logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < int'(SKID_DEPTH); i++) r_mem[i] <= '0;
      end else begin
         if (i_wr_en) begin
            // Credit accounting upstream must never let a capture hit a full buffer.
            assert (r_count != CNT_W'(SKID_DEPTH));
            r_mem[r_wr_ptr] <= i_wr_data;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (i_rd_en) r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({i_wr_en, i_rd_en})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_count     = r_count;
   assign o_rd_data_c = r_mem[r_rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side unload stage: pops the async FIFO under credit control and presents a
// valid/ready stream. Optional statistics counters with FIFO_RD_STATS_EN.
module fifo_rd_stream
   import fifo_rd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned SKID_DEPTH = SKID_DEPTH_DEF
) (
   input  logic              r_clk,
   input  logic              r_rst_n,
`ifdef FIFO_RD_STATS_EN
   input  logic              stat_clr,
   output logic [STAT_W-1:0] stat_words,
   output logic [STAT_W-1:0] stat_stall,
`endif
   fifo_rd_stream_if.master  bus
);

   localparam int unsigned CNT_W = clog2(SKID_DEPTH + 1);

   logic [CNT_W-1:0] w_count;
   logic [CNT_W:0]   w_occ;
   logic             w_credit;
   logic             w_xfer;
   logic             r_inflight;

   // Pop only when occupancy plus the word already in flight leaves room.
   assign w_occ    = (CNT_W + 1)'(w_count) + (CNT_W + 1)'(r_inflight);
   assign w_credit = !bus.r_empty && (w_occ < (CNT_W + 1)'(SKID_DEPTH));

   assign bus.r_en    = r_rst_n && w_credit;
   assign bus.m_valid = (w_count != '0);
   assign w_xfer      = bus.m_valid && bus.m_ready;

   always_ff @(posedge r_clk or negedge r_rst_n) begin
      if (!r_rst_n) r_inflight <= 1'b0;
      else          r_inflight <= w_credit;
   end

   fifo_rd_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .SKID_DEPTH (SKID_DEPTH)
   ) u_buf (
      .clk         (r_clk),
      .rst_n       (r_rst_n),
      .i_wr_en     (bus.r_valid),
      .i_wr_data   (bus.r_data),
      .i_rd_en     (w_xfer),
      .o_count     (w_count),
      .o_rd_data_c (bus.m_data)
   );

`ifdef FIFO_RD_STATS_EN
   logic [STAT_W-1:0] r_stat_words;
   logic [STAT_W-1:0] r_stat_stall;

   // Saturating counters; clear wins over any increment in the same cycle.
   always_ff @(posedge r_clk or negedge r_rst_n) begin
      if (!r_rst_n) begin
         r_stat_words <= '0;
         r_stat_stall <= '0;
      end else if (stat_clr) begin
         r_stat_words <= '0;
         r_stat_stall <= '0;
      end else begin
         if (w_xfer && (r_stat_words != STAT_MAX))
            r_stat_words <= r_stat_words + STAT_W'(1);
         if (bus.m_valid && !bus.m_ready && (r_stat_stall != STAT_MAX))
            r_stat_stall <= r_stat_stall + STAT_W'(1);
      end
   end

   assign stat_words = r_stat_words;
   assign stat_stall = r_stat_stall;
`else
   // Statistics absent: datapath above is unchanged.
`endif

endmodule
